// File: rtl/modem_pkg.sv
// Shared definitions for the modem transmit path: state encoding, default
// framing constants and the payload length clamp.
package modem_pkg;

  localparam int LEN_W = 10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SYNC     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD  = 3'd3;
  localparam logic [2:0] ST_CW       = 3'd4;
  localparam logic [2:0] ST_FLUSH    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'hAA;
  localparam logic [15:0] DEF_SYNC_WORD     = 16'h2DD4;
  localparam int          DEF_MAX_LEN       = 1000;

  // Limit a requested payload length to the message RAM size.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int max_len);
    if (int'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/tx_bit_shifter.sv
// 8-bit load/shift register presenting its MSB, with a down-counter of the
// bits still to follow the current one (terminal count 0 = last bit).
module tx_bit_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       shift,
  output logic       msb,
  output logic       first_bit,
  output logic       last_bit
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  // Load wins over shift so a new byte can replace the last bit on the consuming edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_byte;
      bit_cnt <= 3'd7;
    end else if (shift) begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt - 3'd1;
    end
  end

  assign msb       = shreg[7];
  assign first_bit = (bit_cnt == 3'd7);
  assign last_bit  = (bit_cnt == 3'd0);

endmodule

// File: rtl/tx_sequencer.sv
// Transmit frame sequencer: preamble, sync word and RAM payload streamed MSB
// first to the modulator, or an unmodulated carrier burst, then a flush wait.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a rising edge of i_transmit
// PREAMBLE | shifting out PREAMBLE_BYTES copies of PREAMBLE_BYTE
// SYNC     | shifting out SYNC_WORD; payload byte 0 is prefetched on entry
// PAYLOAD  | shifting out RAM bytes, prefetching one byte ahead
// CW       | carrier only, counting length*8 bit requests
// FLUSH    | waiting for the modulator to finish its last symbol
// DONE     | one-cycle completion pulse
module tx_sequencer
  import modem_pkg::*;
#(
  parameter int          PREAMBLE_BYTES = 4,
  parameter logic [7:0]  PREAMBLE_BYTE  = DEF_PREAMBLE_BYTE,
  parameter logic [15:0] SYNC_WORD      = DEF_SYNC_WORD,
  parameter int          MAX_LEN        = DEF_MAX_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_transmit,
  input  logic       i_cw,
  input  logic [9:0] i_msg_length,
  output logic       o_ram_rd,
  output logic [9:0] o_ram_addr,
  input  logic [7:0] i_ram_data,
  input  logic       i_bit_req,
  output logic       o_bit,
  output logic       o_bit_valid,
  output logic       o_cw,
  output logic       o_tx_en,
  input  logic       i_mod_idle,
  output logic       o_tx_done,
  output logic       o_busy
);

  localparam logic [9:0] PRE_LAST = 10'(PREAMBLE_BYTES - 1);

  logic [2:0]  state, state_nx;
  logic        bit_valid, valid_nx;
  logic [9:0]  byte_cnt, byte_cnt_nx;
  logic [12:0] cw_cnt, cw_cnt_nx;
  logic [9:0]  len_q, len_in;
  logic [9:0]  rd_addr, reads_left;
  logic        ram_rd, rd_q;
  logic [9:0]  ram_addr;
  logic [7:0]  next_byte;
  logic        next_full;
  logic        transmit_q, start_armed;
  logic        load, shift, issue_rd, take_next;
  logic [7:0]  load_byte;
  logic        msb, first_bit, last_bit;
  logic        consume, last_consumed, start, in_frame;

  assign len_in        = clamp_len(i_msg_length, MAX_LEN);
  // start_armed keeps a level held high through reset from looking like an edge
  assign start         = i_transmit & ~transmit_q & start_armed;
  assign consume       = i_bit_req & bit_valid;
  assign last_consumed = consume & last_bit;
  assign in_frame      = (state != ST_IDLE) && (state != ST_DONE);

  tx_bit_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_byte (load_byte),
    .shift     (shift),
    .msb       (msb),
    .first_bit (first_bit),
    .last_bit  (last_bit)
  );

  // Next-state, byte-stream and prefetch decisions.
  always_comb begin
    state_nx    = state;
    valid_nx    = bit_valid;
    byte_cnt_nx = byte_cnt;
    cw_cnt_nx   = cw_cnt;
    load        = 1'b0;
    load_byte   = next_byte;
    shift       = consume;
    issue_rd    = 1'b0;
    take_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (i_cw) begin
            state_nx  = ST_CW;
            cw_cnt_nx = {len_in, 3'b000};
          end else begin
            state_nx    = ST_PREAMBLE;
            load        = 1'b1;
            load_byte   = PREAMBLE_BYTE;
            valid_nx    = 1'b1;
            byte_cnt_nx = PRE_LAST;
          end
        end
      end
      ST_PREAMBLE: begin
        if (last_consumed) begin
          load = 1'b1;
          if (byte_cnt != '0) begin
            load_byte   = PREAMBLE_BYTE;
            byte_cnt_nx = byte_cnt - 10'd1;
          end else begin
            load_byte   = SYNC_WORD[15:8];
            byte_cnt_nx = 10'd1;
            state_nx    = ST_SYNC;
            issue_rd    = (len_q != '0);
          end
        end
      end
      ST_SYNC: begin
        if (last_consumed) begin
          if (byte_cnt != '0) begin
            load        = 1'b1;
            load_byte   = SYNC_WORD[7:0];
            byte_cnt_nx = '0;
          end else if (len_q == '0) begin
            state_nx = ST_FLUSH;
            valid_nx = 1'b0;
          end else begin
            state_nx    = ST_PAYLOAD;
            byte_cnt_nx = len_q - 10'd1;
            load        = next_full;
            take_next   = next_full;
            valid_nx    = next_full;
          end
        end
      end
      ST_PAYLOAD: begin
        issue_rd = consume & first_bit & (reads_left != '0);
        if (!bit_valid) begin
          if (next_full) begin
            load      = 1'b1;
            take_next = 1'b1;
            valid_nx  = 1'b1;
          end
        end else if (last_consumed) begin
          if (byte_cnt == '0) begin
            state_nx = ST_FLUSH;
            valid_nx = 1'b0;
          end else begin
            byte_cnt_nx = byte_cnt - 10'd1;
            load        = next_full;
            take_next   = next_full;
            valid_nx    = next_full;
          end
        end
      end
      ST_CW: begin
        if (cw_cnt == '0) begin
          state_nx = ST_FLUSH;
        end else if (i_bit_req) begin
          cw_cnt_nx = cw_cnt - 13'd1;
          if (cw_cnt == 13'd1) state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_mod_idle) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Dropping the request mid-frame abandons the frame silently.
    if (in_frame && !i_transmit) begin
      state_nx = ST_IDLE;
      valid_nx = 1'b0;
      issue_rd = 1'b0;
      load     = 1'b0;
    end
  end

  // State, counters, RAM read port and the one-byte prefetch register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_valid   <= 1'b0;
      byte_cnt    <= '0;
      cw_cnt      <= '0;
      len_q       <= '0;
      rd_addr     <= '0;
      reads_left  <= '0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      rd_q        <= 1'b0;
      next_byte   <= '0;
      next_full   <= 1'b0;
      transmit_q  <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_valid  <= valid_nx;
      byte_cnt   <= byte_cnt_nx;
      cw_cnt     <= cw_cnt_nx;
      transmit_q <= i_transmit;
      if (!i_transmit) start_armed <= 1'b1;
      ram_rd <= issue_rd;
      if (issue_rd) begin
        ram_addr   <= rd_addr;
        rd_addr    <= rd_addr + 10'd1;
        reads_left <= reads_left - 10'd1;
      end
      rd_q <= ram_rd;
      if (take_next) next_full <= 1'b0;
      if (rd_q) begin
        next_byte <= i_ram_data;
        next_full <= 1'b1;
      end
      if (state == ST_IDLE && start) begin
        len_q      <= len_in;
        rd_addr    <= '0;
        reads_left <= len_in;
        next_full  <= 1'b0;
      end
    end
  end

  assign o_ram_rd    = ram_rd;
  assign o_ram_addr  = ram_addr;
  assign o_bit       = bit_valid & msb;
  assign o_bit_valid = bit_valid | (state == ST_CW);
  assign o_cw        = (state == ST_CW);
  assign o_tx_en     = in_frame;
  assign o_busy      = (state != ST_IDLE);
  assign o_tx_done   = (state == ST_DONE);

endmodule
